// File: rtl/opl3_reg_write_bridge_if.sv
// AXI4-Lite bus bundle for opl3_reg_write_bridge.
// Ports/signals:
//   aw*  : write address channel (4-bit byte address)
//   w*   : write data channel (32-bit data, wstrb carried but unused by the slave)
//   b*   : write response channel
//   ar*  : read address channel
//   r*   : read data channel
// Modports: master drives requests, slave drives responses.
interface opl3_reg_write_bridge_if;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/opl3_reg_write_bridge.sv
// AXI4-Lite slave that queues OPL3 register writes in a FIFO and replays
// them to the OPL3 core with a programmable minimum spacing.
// Ports:
//   clk, reset   : single clock, asynchronous active-high reset
//   s_axi        : AXI4-Lite slave (WRITE 0x0, STATUS 0x4, CONTROL 0x8, SPACING 0xC)
//   opl3_we      : one-cycle write strobe to the core
//   opl3_address : core register address (bit 8 = bank), held between strobes
//   opl3_data    : core register data, held between strobes
module opl3_reg_write_bridge #(
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned DEFAULT_SPACING = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    opl3_reg_write_bridge_if.slave        s_axi,
    output logic                          opl3_we,
    output logic [8:0]                    opl3_address,
    output logic [7:0]                    opl3_data
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} r_state_t;
    typedef enum logic       {D_IDLE, D_ISSUE}       d_state_t;

    // Write side
    w_state_t    w_state_q;
    logic [1:0]  waddr_q;
    logic [23:0] wbuf_q;
    logic        awready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        overflow_q;
    logic [15:0] spacing_q;

    // Read side
    r_state_t    r_state_q;
    logic [1:0]  raddr_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // FIFO: entry = {data[7:0], address[8:0]}
    logic [16:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

    // Drain side
    d_state_t    d_state_q;
    logic        we_q;
    logic [8:0]  addr_out_q;
    logic [7:0]  data_out_q;
    logic [15:0] cnt_q;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi.wstrb, s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.wdata[31:24]};

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // Full is judged on the start-of-cycle count, so a same-cycle pop never rescues a push.
    assign push = (w_state_q == W_ACK) && (waddr_q == 2'd0) && !fifo_full;
    assign pop  = (d_state_q == D_IDLE) && !fifo_empty && (cnt_q == '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        case (raddr_q)
            2'd1:    rdata_d = {16'h0000, 8'(count_q), 5'b00000, overflow_q, fifo_full, fifo_empty};
            2'd3:    rdata_d = {16'h0000, spacing_q};
            default: rdata_d = '0;
        endcase
    end

    // Write FSM plus the registers it owns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q  <= W_IDLE;
            waddr_q    <= '0;
            wbuf_q     <= '0;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            overflow_q <= 1'b0;
            spacing_q  <= 16'(DEFAULT_SPACING);
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (s_axi.awvalid && s_axi.wvalid) begin
                        waddr_q   <= s_axi.awaddr[3:2];
                        wbuf_q    <= s_axi.wdata[23:0];
                        awready_q <= 1'b1;
                        w_state_q <= W_ACK;
                    end
                end
                W_ACK: begin
                    awready_q <= 1'b0;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= RESP_OKAY;
                    case (waddr_q)
                        2'd0: begin
                            if (fifo_full) begin
                                overflow_q <= 1'b1;
                                bresp_q    <= RESP_SLVERR;
                            end
                        end
                        2'd2: begin
                            if (wbuf_q[0]) overflow_q <= 1'b0;
                        end
                        2'd3: spacing_q <= wbuf_q[15:0];
                        default: ;
                    endcase
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Read FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (s_axi.arvalid) begin
                        raddr_q   <= s_axi.araddr[3:2];
                        arready_q <= 1'b1;
                        r_state_q <= R_ACK;
                    end
                end
                R_ACK: begin
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    rdata_q   <= rdata_d;
                    r_state_q <= R_RESP;
                end
                R_RESP: begin
                    if (s_axi.rready) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // FIFO storage carries no reset; validity is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {wbuf_q[23:16], wbuf_q[8:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    // Drain FSM: pop in D_IDLE, strobe during D_ISSUE, then arm the spacing counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_state_q  <= D_IDLE;
            we_q       <= 1'b0;
            addr_out_q <= '0;
            data_out_q <= '0;
            cnt_q      <= '0;
        end else begin
            case (d_state_q)
                D_IDLE: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 16'd1;
                    if (pop) begin
                        we_q       <= 1'b1;
                        addr_out_q <= mem_q[rd_ptr_q][8:0];
                        data_out_q <= mem_q[rd_ptr_q][16:9];
                        d_state_q  <= D_ISSUE;
                    end
                end
                D_ISSUE: begin
                    we_q      <= 1'b0;
                    cnt_q     <= (spacing_q == '0) ? '0 : spacing_q - 16'd1;
                    d_state_q <= D_IDLE;
                end
                default: d_state_q <= D_IDLE;
            endcase
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = RESP_OKAY;
    assign s_axi.rvalid  = rvalid_q;

    assign opl3_we      = we_q;
    assign opl3_address = addr_out_q;
    assign opl3_data    = data_out_q;
endmodule

// File: tb/tb_opl3_reg_write_bridge.sv
// Self-checking bench for opl3_reg_write_bridge: register-access vector table
// followed by hand-written multi-cycle sequences.
module tb_opl3_reg_write_bridge;
    logic       clk;
    logic       reset;
    logic       opl3_we;
    logic [8:0] opl3_address;
    logic [7:0] opl3_data;

    opl3_reg_write_bridge_if axi ();

    opl3_reg_write_bridge #(
        .FIFO_DEPTH      (16),
        .DEFAULT_SPACING (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axi        (axi),
        .opl3_we      (opl3_we),
        .opl3_address (opl3_address),
        .opl3_data    (opl3_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [8:0] a;
        logic [7:0] d;
    } strobe_t;
    strobe_t strobes[$];

    always @(negedge clk) begin
        if (opl3_we === 1'b1) strobes.push_back('{cyc, opl3_address, opl3_data});
    end

    int n_checks = 0;
    int n_fail   = 0;
    int last_wack_cyc;
    int last_b_lat;
    int last_ar_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic complete_write(output logic [1:0] resp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (axi.awready && axi.wready) begin
                seen = 1'b1;
                break;
            end
        end
        last_wack_cyc = cyc;
        check("aw_w_handshake", {31'b0, seen}, 32'd1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b1;
        seen = 1'b0;
        last_b_lat = -1;
        for (int i = 0; i < 50; i++) begin
            if (axi.bvalid) begin
                seen = 1'b1;
                last_b_lat = i;
                break;
            end
            @(negedge clk);
        end
        check("b_handshake", {31'b0, seen}, 32'd1);
        resp = axi.bresp;
        @(negedge clk);
        axi.bready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
        @(negedge clk);
        axi.awaddr  = a;
        axi.wdata   = d;
        axi.wstrb   = 4'hF;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        complete_write(resp);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        bit seen;
        @(negedge clk);
        axi.araddr  = a;
        axi.arvalid = 1'b1;
        seen = 1'b0;
        last_ar_lat = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (axi.arready) begin
                seen = 1'b1;
                last_ar_lat = i;
                break;
            end
        end
        check("ar_handshake", {31'b0, seen}, 32'd1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (axi.rvalid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("r_handshake", {31'b0, seen}, 32'd1);
        check("rresp_okay", {30'b0, axi.rresp}, 32'd0);
        d = axi.rdata;
        @(negedge clk);
        axi.rready = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (strobes.size() >= n) break;
            @(negedge clk);
        end
        check("strobe_count", 32'(strobes.size()), 32'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit          is_write;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          n_ok;
        bit          early_rdy;

        vecs[0]  = '{1'b0, 4'h4, 32'h0,        32'h0000_0001, "status_after_reset"};
        vecs[1]  = '{1'b0, 4'hC, 32'h0,        32'h0000_0020, "spacing_default"};
        vecs[2]  = '{1'b0, 4'h0, 32'h0,        32'h0000_0000, "read_write_reg_zero"};
        vecs[3]  = '{1'b0, 4'h8, 32'h0,        32'h0000_0000, "read_control_zero"};
        vecs[4]  = '{1'b1, 4'hC, 32'hABCD1234, 32'h0000_0000, "wr_spacing_okay"};
        vecs[5]  = '{1'b0, 4'hC, 32'h0,        32'h0000_1234, "spacing_readback"};
        vecs[6]  = '{1'b1, 4'h4, 32'hFFFFFFFF, 32'h0000_0000, "wr_status_okay"};
        vecs[7]  = '{1'b0, 4'h4, 32'h0,        32'h0000_0001, "status_read_only"};
        vecs[8]  = '{1'b1, 4'h8, 32'h0,        32'h0000_0000, "wr_control_okay"};
        vecs[9]  = '{1'b1, 4'hC, 32'h0000_0003, 32'h0000_0000, "wr_spacing_3"};
        vecs[10] = '{1'b0, 4'hC, 32'h0,        32'h0000_0003, "spacing_3_readback"};

        reset       = 1'b1;
        axi.awaddr  = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.araddr  = '0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {20'b0, axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid,
               opl3_we, axi.bresp, axi.rresp, 2'b0},
              32'd0);
        check("reset_opl3_bus", {15'b0, opl3_address, opl3_data}, 32'd0);
        reset = 1'b0;

        // Register map vectors
        foreach (vecs[i]) begin
            if (vecs[i].is_write) begin
                axi_write(vecs[i].addr, vecs[i].data, resp);
                check(vecs[i].name, {30'b0, resp}, vecs[i].exp);
            end else begin
                axi_read(vecs[i].addr, rd);
                check(vecs[i].name, rd, vecs[i].exp);
            end
        end
        axi_read(4'h4, rd);
        check("read_latency", 32'(last_ar_lat), 32'd0);

        // Single write reaches the core, two cycles after W_ACK
        repeat (10) @(negedge clk);
        strobes.delete();
        axi_write(4'h0, 32'h00AB_0120, resp);
        check("single_bresp", {30'b0, resp}, 32'd0);
        check("bvalid_latency", 32'(last_b_lat), 32'd0);
        repeat (40) @(negedge clk);
        check("single_strobe_count", 32'(strobes.size()), 32'd1);
        if (strobes.size() > 0) begin
            check("single_addr", {23'b0, strobes[0].a}, 32'h120);
            check("single_data", {24'b0, strobes[0].d}, 32'hAB);
            check("push_to_strobe", 32'(strobes[0].cyc - last_wack_cyc), 32'd2);
        end
        check("hold_addr", {23'b0, opl3_address}, 32'h120);
        check("hold_data", {24'b0, opl3_data}, 32'hAB);

        // SPACING=5: four strobes 6 cycles apart, in push order
        axi_write(4'hC, 32'd5, resp);
        repeat (10) @(negedge clk);
        strobes.delete();
        for (int i = 0; i < 4; i++) axi_write(4'h0, 32'((32'h10 + i) << 16) | 32'(32'h40 + i), resp);
        wait_strobes(4, 200);
        if (strobes.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("sp5_addr", {23'b0, strobes[i].a}, 32'(32'h40 + i));
                check("sp5_data", {24'b0, strobes[i].d}, 32'(32'h10 + i));
                if (i > 0) check("sp5_gap", 32'(strobes[i].cyc - strobes[i-1].cyc), 32'd6);
            end
        end

        // Overflow: one drains, 16 buffer, the 18th write is dropped
        axi_write(4'hC, 32'h0000_FFFF, resp);
        repeat (10) @(negedge clk);
        strobes.delete();
        n_ok = 0;
        for (int i = 0; i < 17; i++) begin
            axi_write(4'h0, 32'(i), resp);
            if (resp == 2'b00) n_ok++;
        end
        check("burst_okay_count", 32'(n_ok), 32'd17);
        axi_read(4'h4, rd);
        check("status_full_no_ovf", rd, 32'h0000_1002);
        axi_write(4'h0, 32'h0000_0055, resp);
        check("overflow_slverr", {30'b0, resp}, 32'h2);
        axi_read(4'h4, rd);
        check("status_full_ovf", rd, 32'h0000_1006);
        check("burst_strobes", 32'(strobes.size()), 32'd1);
        axi_write(4'h8, 32'h1, resp);
        check("ctrl_clear_okay", {30'b0, resp}, 32'd0);
        axi_read(4'h4, rd);
        check("overflow_cleared", rd, 32'h0000_1002);

        // Lone awvalid waits for wvalid; reset mid-response discards the queue
        do_reset();
        axi_read(4'h4, rd);
        check("status_after_reset2", rd, 32'h0000_0001);
        axi_write(4'hC, 32'h0000_FFFF, resp);
        strobes.delete();
        axi_write(4'h0, 32'h0011_0001, resp);
        @(negedge clk);
        axi.awaddr  = 4'h0;
        axi.wdata   = 32'h0022_0002;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b0;
        early_rdy   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            early_rdy = early_rdy | axi.awready | axi.wready;
        end
        check("lone_aw_no_ready", {31'b0, early_rdy}, 32'd0);
        axi.wvalid = 1'b1;
        complete_write(resp);
        check("lone_aw_bresp", {30'b0, resp}, 32'd0);
        axi_read(4'h4, rd);
        check("lone_aw_one_entry", rd, 32'h0000_0100);
        axi_write(4'h0, 32'h0033_0003, resp);
        axi_read(4'h4, rd);
        check("two_queued", rd, 32'h0000_0200);

        @(negedge clk);
        axi.awaddr  = 4'h0;
        axi.wdata   = 32'h0044_0004;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (axi.awready) break;
        end
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        check("bvalid_before_reset", {31'b0, axi.bvalid}, 32'd1);
        reset = 1'b1;
        #1;
        check("bvalid_async_clear", {31'b0, axi.bvalid}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("no_strobe_after_reset", 32'(strobes.size()), 32'd1);
        axi_read(4'h4, rd);
        check("empty_after_reset", rd, 32'h0000_0001);

        // Default spacing countdown is not shortened; SPACING=0 gives 2-cycle gaps
        strobes.delete();
        for (int i = 0; i < 4; i++) axi_write(4'h0, 32'((32'hA0 + i) << 16) | 32'(32'h100 + i), resp);
        axi_write(4'hC, 32'h0, resp);
        wait_strobes(4, 200);
        if (strobes.size() >= 4) begin
            check("gap_default", 32'(strobes[1].cyc - strobes[0].cyc), 32'd33);
            check("gap_sp0_a", 32'(strobes[2].cyc - strobes[1].cyc), 32'd2);
            check("gap_sp0_b", 32'(strobes[3].cyc - strobes[2].cyc), 32'd2);
            check("bank1_addr", {23'b0, strobes[3].a}, 32'h103);
            check("bank1_data", {24'b0, strobes[3].d}, 32'hA3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
